// File: rtl/openddr_rd_return.sv
// Read-return path: pairs PHY read beats with the outstanding AXI read descriptors
// they belong to and replays them on the AXI4 R channel with backpressure.
module openddr_rd_return #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 12,
    parameter int CMD_DEPTH  = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic                         mck,
    input  logic                         mc_rst_b,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ID_WIDTH-1:0]          cmd_id,
    input  logic [7:0]                   cmd_len,
    input  logic [DATA_WIDTH-1:0]        dfi_rddata,
    input  logic                         dfi_rddata_valid,
    output logic [ID_WIDTH-1:0]          axi_rid,
    output logic [DATA_WIDTH-1:0]        axi_rdata,
    output logic [1:0]                   axi_rresp,
    output logic                         axi_rlast,
    output logic                         axi_rvalid,
    input  logic                         axi_rready,
    input  logic                         err_clr,
    output logic                         ovf_err,
    output logic                         orphan_err,
    output logic [$clog2(CMD_DEPTH):0]   outstanding
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
    localparam logic [DAW:0] DAT_FULL = (DAW+1)'(DATA_DEPTH);
    localparam logic [CAW:0] CMD_ONE  = (CAW+1)'(1);
    localparam logic [DAW:0] DAT_ONE  = (DAW+1)'(1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [7:0]          len;
    } cmd_t;

    cmd_t                  cmd_mem [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DATA_DEPTH];

    logic [CAW:0] cmd_wr, cmd_rd, cmd_cnt;
    logic [DAW:0] dat_wr, dat_rd, dat_cnt;
    logic [7:0]   beat_cnt;
    logic         rst_done;
    logic         cmd_empty, cmd_full, dat_empty, dat_full;
    logic         r_fire, cmd_pop, cmd_push, beat_push, ovf_set, orphan_set;
    cmd_t         head;

    always_comb begin
        cmd_cnt   = cmd_wr - cmd_rd;
        dat_cnt   = dat_wr - dat_rd;
        cmd_empty = (cmd_cnt == '0);
        cmd_full  = (cmd_cnt == CMD_FULL);
        dat_empty = (dat_cnt == '0);
        dat_full  = (dat_cnt == DAT_FULL);
        head      = cmd_mem[cmd_rd[CAW-1:0]];

        // Head fields are gated so the R bus reads as zero whenever nothing is presented.
        axi_rvalid = !cmd_empty && !dat_empty;
        axi_rid    = axi_rvalid ? head.id : '0;
        axi_rdata  = axi_rvalid ? data_mem[dat_rd[DAW-1:0]] : '0;
        axi_rlast  = axi_rvalid && (beat_cnt == head.len);
        axi_rresp  = 2'b00;

        r_fire  = axi_rvalid && axi_rready;
        cmd_pop = r_fire && axi_rlast;
        // A retiring last beat frees a slot in the same cycle, so a full FIFO can still accept.
        cmd_ready = rst_done && (!cmd_full || cmd_pop);
        cmd_push  = cmd_valid && cmd_ready;

        // Beat acceptance uses start-of-cycle occupancy only; orphan takes priority over overflow.
        orphan_set = dfi_rddata_valid && cmd_empty;
        ovf_set    = dfi_rddata_valid && !cmd_empty && dat_full;
        beat_push  = dfi_rddata_valid && !cmd_empty && !dat_full;

        outstanding = cmd_cnt;
    end

    always_ff @(posedge mck or negedge mc_rst_b) begin
        if (!mc_rst_b) begin
            cmd_wr     <= '0;
            cmd_rd     <= '0;
            dat_wr     <= '0;
            dat_rd     <= '0;
            beat_cnt   <= '0;
            rst_done   <= 1'b0;
            ovf_err    <= 1'b0;
            orphan_err <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (cmd_push)
                cmd_wr <= cmd_wr + CMD_ONE;
            if (beat_push)
                dat_wr <= dat_wr + DAT_ONE;
            if (r_fire) begin
                dat_rd <= dat_rd + DAT_ONE;
                if (axi_rlast) begin
                    cmd_rd   <= cmd_rd + CMD_ONE;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (ovf_set)
                ovf_err <= 1'b1;
            else if (err_clr)
                ovf_err <= 1'b0;
            if (orphan_set)
                orphan_err <= 1'b1;
            else if (err_clr)
                orphan_err <= 1'b0;
        end
    end

    always_ff @(posedge mck) begin
        if (cmd_push)
            cmd_mem[cmd_wr[CAW-1:0]] <= '{id: cmd_id, len: cmd_len};
        if (beat_push)
            data_mem[dat_wr[DAW-1:0]] <= dfi_rddata;
    end
endmodule
